// File: rtl/balance_pkg.sv
// Shared widths, collision bit indices and physics FSM encoding for the balance-board game.
package balance_pkg;

    localparam int unsigned VEL_W = 11;
    localparam int unsigned POS_W = 11;
    localparam int unsigned COL_W = 4;

    localparam int unsigned COL_LEFT   = 0;
    localparam int unsigned COL_RIGHT  = 1;
    localparam int unsigned COL_TOP    = 2;
    localparam int unsigned COL_BOTTOM = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_CLAMP = 2'd2
    } state_e;

endpackage

// File: rtl/solve_position_if.sv
// Velocity in / position and collision out bundle between solve_position and its neighbours.
interface solve_position_if;
    import balance_pkg::*;

    logic                    enable;
    logic signed [VEL_W-1:0] velocity_x;
    logic signed [VEL_W-1:0] velocity_y;
    logic [POS_W-1:0]        position_x;
    logic [POS_W-1:0]        position_y;
    logic [COL_W-1:0]        collision;
    logic                    update_done;

    modport master (
        output enable, velocity_x, velocity_y,
        input  position_x, position_y, collision, update_done
    );

    modport slave (
        input  enable, velocity_x, velocity_y,
        output position_x, position_y, collision, update_done
    );

endinterface

// File: rtl/axis_integrator.sv
// One axis of the ball: registered position+velocity add on step, wall clamp and contact flags on clamp.
module axis_integrator
    import balance_pkg::*;
#(
    parameter int unsigned LO   = 8,
    parameter int unsigned HI   = 631,
    parameter int unsigned FRAC = 4,
    parameter int unsigned INIT = 320
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    input  logic                    clamp,
    input  logic signed [VEL_W-1:0] velocity,
    output logic [POS_W-1:0]        pos_px,
    output logic                    hit_lo,
    output logic                    hit_hi
);

    localparam int unsigned PW = POS_W + FRAC;
    localparam int unsigned EW = 13 + FRAC;

    localparam logic signed [EW-1:0] LO_F = EW'(LO << FRAC);
    localparam logic signed [EW-1:0] HI_F = EW'(HI << FRAC);

    logic signed [EW-1:0] ext_q, ext_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic                 hit_lo_q, hit_lo_d;
    logic                 hit_hi_q, hit_hi_d;

    // Extended sum is wide enough that a negative result stays negative for the clamp.
    always_comb begin
        ext_d    = ext_q;
        pos_d    = pos_q;
        hit_lo_d = hit_lo_q;
        hit_hi_d = hit_hi_q;
        if (step) begin
            ext_d = $signed({{(EW-PW){1'b0}}, pos_q})
                  + $signed({{(EW-VEL_W){velocity[VEL_W-1]}}, velocity});
        end
        if (clamp) begin
            hit_lo_d = 1'b0;
            hit_hi_d = 1'b0;
            if (ext_q < LO_F) begin
                pos_d    = PW'(LO_F);
                hit_lo_d = 1'b1;
            end else if (ext_q > HI_F) begin
                pos_d    = PW'(HI_F);
                hit_hi_d = 1'b1;
            end else begin
                pos_d = PW'(ext_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q    <= '0;
            pos_q    <= PW'(INIT << FRAC);
            hit_lo_q <= 1'b0;
            hit_hi_q <= 1'b0;
        end else begin
            ext_q    <= ext_d;
            pos_q    <= pos_d;
            hit_lo_q <= hit_lo_d;
            hit_hi_q <= hit_hi_d;
        end
    end

    assign pos_px = pos_q[PW-1:FRAC];
    assign hit_lo = hit_lo_q;
    assign hit_hi = hit_hi_q;

endmodule

// File: rtl/solve_position.sv
// Ball position integrator: physics tick divider, STEP/CLAMP sequencer and per-axis integrators.
module solve_position
    import balance_pkg::*;
#(
    parameter int unsigned BOARD_W  = 640,
    parameter int unsigned BOARD_H  = 480,
    parameter int unsigned RADIUS   = 8,
    parameter int unsigned FRAC     = 4,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned X_INIT   = 320,
    parameter int unsigned Y_INIT   = 240
) (
    input  logic             clk,
    input  logic             rst,
    solve_position_if.slave  bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic             update_done_q, update_done_d;
    logic             tick_c;
    logic [POS_W-1:0] pos_x_c, pos_y_c;
    logic             lo_x_c, hi_x_c, lo_y_c, hi_y_c;
    logic [COL_W-1:0] collision_c;

    assign tick_c = bus.enable && (cnt_q == CNT_W'(TICK_DIV - 1));

    // Tick divider runs only while enabled and restarts from zero otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.enable || tick_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // An update in flight always completes, even if enable drops.
    always_comb begin
        state_d       = state_q;
        update_done_d = 1'b0;
        case (state_q)
            ST_IDLE:  if (tick_c) state_d = ST_STEP;
            ST_STEP:  state_d = ST_CLAMP;
            ST_CLAMP: begin
                state_d       = ST_IDLE;
                update_done_d = 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            update_done_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            update_done_q <= update_done_d;
        end
    end

    axis_integrator #(
        .LO   (RADIUS),
        .HI   (BOARD_W - 1 - RADIUS),
        .FRAC (FRAC),
        .INIT (X_INIT)
    ) u_axis_x (
        .clk      (clk),
        .rst      (rst),
        .step     (state_q == ST_STEP),
        .clamp    (state_q == ST_CLAMP),
        .velocity (bus.velocity_x),
        .pos_px   (pos_x_c),
        .hit_lo   (lo_x_c),
        .hit_hi   (hi_x_c)
    );

    axis_integrator #(
        .LO   (RADIUS),
        .HI   (BOARD_H - 1 - RADIUS),
        .FRAC (FRAC),
        .INIT (Y_INIT)
    ) u_axis_y (
        .clk      (clk),
        .rst      (rst),
        .step     (state_q == ST_STEP),
        .clamp    (state_q == ST_CLAMP),
        .velocity (bus.velocity_y),
        .pos_px   (pos_y_c),
        .hit_lo   (lo_y_c),
        .hit_hi   (hi_y_c)
    );

    always_comb begin
        collision_c             = '0;
        collision_c[COL_LEFT]   = lo_x_c;
        collision_c[COL_RIGHT]  = hi_x_c;
        collision_c[COL_TOP]    = lo_y_c;
        collision_c[COL_BOTTOM] = hi_y_c;
    end

    assign bus.position_x  = pos_x_c;
    assign bus.position_y  = pos_y_c;
    assign bus.collision   = collision_c;
    assign bus.update_done = update_done_q;

endmodule

// File: tb/tb_solve_position.sv
// Scoreboard bench for solve_position with a 4-cycle physics tick.
module tb_solve_position;
    import balance_pkg::*;

    localparam int unsigned TICK = 4;
    localparam int X_LO = 8 * 16;
    localparam int X_HI = 631 * 16;
    localparam int Y_LO = 8 * 16;
    localparam int Y_HI = 471 * 16;

    typedef struct {
        int x;
        int y;
        int col;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    solve_position_if bus ();

    solve_position #(.TICK_DIV(TICK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    int   mx;
    int   my;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pops one expectation per update_done pulse and checks the pulse spacing.
    task automatic monitor();
        int   last = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last = -1;
            end else if (bus.update_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_update: pulse with nothing expected (x=%0d y=%0d col=%0d)",
                             bus.position_x, bus.position_y, bus.collision);
                end else begin
                    e = sb.pop_front();
                    check("position_x", int'(bus.position_x), e.x);
                    check("position_y", int'(bus.position_y), e.y);
                    check("collision",  int'(bus.collision),  e.col);
                end
                if (last >= 0) check("update_period", cyc - last, TICK);
                last = cyc;
            end
        end
    endtask

    task automatic model_step(int vx, int vy);
        int   ex;
        int   ey;
        exp_t e;
        ex    = mx + vx;
        ey    = my + vy;
        e.col = 0;
        if (ex < X_LO)      begin mx = X_LO; e.col += 1; end
        else if (ex > X_HI) begin mx = X_HI; e.col += 2; end
        else                mx = ex;
        if (ey < Y_LO)      begin my = Y_LO; e.col += 4; end
        else if (ey > Y_HI) begin my = Y_HI; e.col += 8; end
        else                my = ey;
        e.x = mx / 16;
        e.y = my / 16;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_x"},    int'(bus.position_x), 320);
        check({tag, "_y"},    int'(bus.position_y), 240);
        check({tag, "_col"},  int'(bus.collision), 0);
        check({tag, "_done"}, int'(bus.update_done), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        mx  = 320 * 16;
        my  = 240 * 16;
    endtask

    task automatic run(int vx, int vy, int n);
        int target;
        int budget;
        bus.velocity_x = VEL_W'(vx);
        bus.velocity_y = VEL_W'(vy);
        bus.enable     = 1'b1;
        for (int i = 0; i < n; i++) model_step(vx, vy);
        target = done_cnt + n;
        budget = n * TICK + 12;
        for (int i = 0; i < budget && done_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL update_timeout: got %0d updates, expected %0d", done_cnt - (target - n), n);
            sb.delete();
        end
    endtask

    initial begin
        int base;
        int lat;

        rst            = 1'b0;
        bus.enable     = 1'b1;
        bus.velocity_x = VEL_W'(300);
        bus.velocity_y = VEL_W'(-5);
        mx             = 320 * 16;
        my             = 240 * 16;
        fork
            monitor();
        join_none

        // Reset holds outputs regardless of inputs; idle with enable low produces nothing.
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        bus.enable = 1'b0;
        rst        = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_no_update", done_cnt, 0);

        // Whole-pixel steps plus first-update latency from enable.
        do_reset();
        bus.velocity_x = VEL_W'(16);
        bus.velocity_y = VEL_W'(0);
        model_step(16, 0);
        base = done_cnt;
        @(negedge clk);
        bus.enable = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base) begin
                lat = i;
                break;
            end
        end
        check("first_latency", lat, 6);
        run(16, 0, 4);

        // Fractional accumulation.
        run(1, 0, 32);
        do_reset();
        run(-1, 0, 1);
        check("frac_neg_x", int'(bus.position_x), 319);

        // Left wall: reach exactly lo without contact, then press, then leave.
        do_reset();
        run(-16, 0, 312);
        check("wall_reach_x", int'(bus.position_x), 8);
        check("wall_reach_col", int'(bus.collision), 0);
        run(-16, 0, 3);
        check("wall_press_col", int'(bus.collision), 1);
        run(16, 0, 1);
        check("wall_leave_x", int'(bus.position_x), 9);

        // Bottom-right corner saturation.
        do_reset();
        run(1023, 1023, 8);
        check("corner_x", int'(bus.position_x), 631);
        check("corner_y", int'(bus.position_y), 471);
        check("corner_col", int'(bus.collision), 10);

        // Reset landing in CLAMP aborts the update.
        do_reset();
        run(16, 0, 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        base       = done_cnt;
        bus.enable = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        mx  = 320 * 16;
        my  = 240 * 16;
        repeat (10) @(negedge clk);
        check("mid_rst_no_update", done_cnt - base, 0);

        // Enable dropped during STEP: in-flight update completes, then nothing more.
        bus.velocity_x = VEL_W'(16);
        bus.velocity_y = VEL_W'(0);
        model_step(16, 0);
        base = done_cnt;
        @(negedge clk);
        bus.enable = 1'b1;
        repeat (4) @(negedge clk);
        bus.enable = 1'b0;
        repeat (10) @(negedge clk);
        check("drop_en_update", done_cnt - base, 1);
        repeat (30) @(negedge clk);
        check("drop_en_quiet", done_cnt - base, 1);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
